canvas_sequencer: RTL and testbench

//  Top-level controller for the 28x28 drawing canvas and the MNIST classifier.
//  - Gates drawing into the canvas.
//  - Issues canvas clears.
//  - On a classify request, freezes the canvas and streams all 784 pixels to
//    the NN engine over a valid/ready handshake.
//  - Waits for the digit result, with a timeout.

---
 rtl/canvas_pkg.sv | 16 +
 rtl/btn_edge.sv | 25 ++
 rtl/canvas_sequencer.sv | 142 ++++++++++++++
 tb/tb_canvas_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canvas_pkg.sv
// Shared definitions for the drawing canvas, its sequencer and the NN top.
package canvas_pkg;

  localparam int GRID    = 28;
  localparam int PIX_W   = 16;
  localparam int CLASS_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SCAN  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/btn_edge.sv
// Registered rising-edge detector for a level button input.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Next history value is simply the current button level.
  always_comb begin
    prev_d = din;
  end

  // History register; cleared so a button held through reset fires once after it.
  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise = din & ~prev_q;

endmodule

// File: rtl/canvas_sequencer.sv
// Canvas controller: gates drawing, issues clears, streams the frozen canvas
// to the NN engine row-major and collects the digit result with a timeout.
module canvas_sequencer #(
  parameter int GRID    = canvas_pkg::GRID,
  parameter int PIX_W   = canvas_pkg::PIX_W,
  parameter int CLASS_W = canvas_pkg::CLASS_W,
  parameter int TIMEOUT = 2 ** 20
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               classify,
  input  logic               clear,
  input  logic               draw,
  output logic               canvas_clear,
  output logic               canvas_run,
  output logic [4:0]         rd_x,
  output logic [4:0]         rd_y,
  input  logic [PIX_W-1:0]   rd_data,
  output logic               pix_valid,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_last,
  input  logic               pix_ready,
  input  logic               nn_done,
  input  logic [CLASS_W-1:0] nn_digit,
  output logic [CLASS_W-1:0] digit,
  output logic               digit_valid,
  output logic               busy,
  output logic               timeout_err
);

  import canvas_pkg::*;

  localparam int             TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
  localparam logic [4:0]     EDGE   = 5'(GRID - 1);

  seq_state_t         state_q, state_d;
  logic [4:0]         rd_x_q, rd_x_d;
  logic [4:0]         rd_y_q, rd_y_d;
  logic [TW-1:0]      cnt_q, cnt_d;
  logic [CLASS_W-1:0] digit_q, digit_d;
  logic               dv_q, dv_d;
  logic               terr_q, terr_d;
  logic               cls_e, clr_e;
  logic               last_pix;

  btn_edge u_cls_edge (.clk(Clk), .rst(Reset), .din(classify), .rise(cls_e));
  btn_edge u_clr_edge (.clk(Clk), .rst(Reset), .din(clear),    .rise(clr_e));

  assign last_pix = (rd_x_q == EDGE) && (rd_y_q == EDGE);

  // Next-state, scan address, timeout counter and result bookkeeping.
  always_comb begin
    state_d = state_q;
    rd_x_d  = rd_x_q;
    rd_y_d  = rd_y_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    dv_d    = dv_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Clear has priority over classify when both buttons rise together.
        if (clr_e) begin
          state_d = S_CLEAR;
          dv_d    = 1'b0;
          terr_d  = 1'b0;
        end else if (cls_e) begin
          state_d = S_SCAN;
          rd_x_d  = '0;
          rd_y_d  = '0;
          dv_d    = 1'b0;
          terr_d  = 1'b0;
        end
      end
      S_CLEAR: state_d = S_IDLE;
      S_SCAN: begin
        if (pix_ready) begin
          if (last_pix) begin
            state_d = S_WAIT;
            rd_x_d  = '0;
            rd_y_d  = '0;
            cnt_d   = '0;
          end else if (rd_x_q == EDGE) begin
            rd_x_d = '0;
            rd_y_d = rd_y_q + 5'd1;
          end else begin
            rd_x_d = rd_x_q + 5'd1;
          end
        end
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts as a result.
        if (nn_done) begin
          state_d = S_DONE;
          digit_d = nn_digit;
          dv_d    = 1'b1;
        end else if (cnt_q == T_LAST) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any stream in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      dv_q    <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      dv_q    <= dv_d;
      terr_q  <= terr_d;
    end
  end

  assign canvas_clear = (state_q == S_CLEAR);
  assign canvas_run   = ((state_q == S_IDLE) || (state_q == S_DONE)) & draw;
  assign pix_valid    = (state_q == S_SCAN);
  assign pix_data     = (state_q == S_SCAN) ? rd_data : '0;
  assign pix_last     = (state_q == S_SCAN) && last_pix;
  assign busy         = (state_q == S_SCAN) || (state_q == S_WAIT);
  assign rd_x         = rd_x_q;
  assign rd_y         = rd_y_q;
  assign digit        = digit_q;
  assign digit_valid  = dv_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_canvas_sequencer.sv
// Directed bench for canvas_sequencer with a small canvas model.
module tb_canvas_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        classify = 1'b0;
  logic        clear = 1'b0;
  logic        draw = 1'b0;
  logic        canvas_clear, canvas_run;
  logic [4:0]  rd_x, rd_y;
  logic [15:0] rd_data;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic        pix_last;
  logic        pix_ready = 1'b0;
  logic        nn_done = 1'b0;
  logic [3:0]  nn_digit = 4'd0;
  logic [3:0]  digit;
  logic        digit_valid, busy, timeout_err;

  int errors = 0;
  int checks = 0;

  canvas_sequencer #(.GRID(28), .PIX_W(16), .CLASS_W(4), .TIMEOUT(64)) dut (
    .Clk(Clk), .Reset(Reset), .classify(classify), .clear(clear), .draw(draw),
    .canvas_clear(canvas_clear), .canvas_run(canvas_run),
    .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .pix_ready(pix_ready), .nn_done(nn_done), .nn_digit(nn_digit),
    .digit(digit), .digit_valid(digit_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  // Canvas contents: unique value per (x, y).
  function automatic logic [15:0] pix_model(input logic [4:0] x, input logic [4:0] y);
    return {y, 1'b1, x, x ^ y};
  endfunction

  assign rd_data = pix_model(rd_x, rd_y);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic start_classify();
    classify = 1'b1;
    @(negedge Clk);
    classify = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({canvas_clear, canvas_run, pix_valid, pix_last, busy, digit_valid, timeout_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: clr=%b run=%b pv=%b pl=%b busy=%b dv=%b terr=%b, want all 0",
               canvas_clear, canvas_run, pix_valid, pix_last, busy, digit_valid, timeout_err);
    end
    checks++;
    if (rd_x !== 5'd0 || rd_y !== 5'd0 || digit !== 4'd0 || pix_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_data: x=%0d y=%0d digit=%0d pdata=%h, want 0", rd_x, rd_y, digit, pix_data);
    end
    Reset = 1'b0;
    @(negedge Clk);
    start_classify();
    pix_ready = 1'b1;
    for (int i = 0; i < 400 && rd_y != 5'd10; i++) @(negedge Clk);
    checks++;
    if (rd_y !== 5'd10 || pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_reach_row10: y=%0d pv=%b, want y=10 pv=1", rd_y, pix_valid);
    end
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    pix_ready = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || rd_x !== 5'd0 || rd_y !== 5'd0 ||
        digit_valid !== 1'b0 || timeout_err !== 1'b0 || canvas_clear !== 1'b0) begin
      errors++;
      $display("FAIL reset_midscan: pv=%b busy=%b x=%0d y=%0d dv=%b terr=%b clr=%b, want all 0",
               pix_valid, busy, rd_x, rd_y, digit_valid, timeout_err, canvas_clear);
    end
    @(negedge Clk);
  endtask

  task automatic test_stream();
    logic [4:0] ex, ey;
    classify = 1'b1;
    @(negedge Clk);
    classify = 1'b0;
    pix_ready = 1'b1;
    for (int k = 0; k < 784; k++) begin
      ex = 5'(k % 28);
      ey = 5'(k / 28);
      checks++;
      if (pix_valid !== 1'b1 || rd_x !== ex || rd_y !== ey || pix_data !== pix_model(ex, ey) ||
          pix_last !== (k == 783) || canvas_run !== 1'b0) begin
        errors++;
        $display("FAIL stream_pix%0d: pv=%b x=%0d y=%0d data=%h last=%b run=%b, want pv=1 x=%0d y=%0d data=%h last=%b run=0",
                 k, pix_valid, rd_x, rd_y, pix_data, pix_last, canvas_run, ex, ey, pix_model(ex, ey), k == 783);
      end
      @(negedge Clk);
    end
    pix_ready = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b1 || rd_x !== 5'd0 || rd_y !== 5'd0) begin
      errors++;
      $display("FAIL stream_wait_entry: pv=%b busy=%b x=%0d y=%0d, want pv=0 busy=1 x=0 y=0",
               pix_valid, busy, rd_x, rd_y);
    end
    repeat (49) @(negedge Clk);
    nn_done = 1'b1;
    nn_digit = 4'd7;
    @(negedge Clk);
    nn_done = 1'b0;
    nn_digit = 4'd0;
    checks++;
    if (digit !== 4'd7 || digit_valid !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL stream_result: digit=%0d dv=%b busy=%b terr=%b, want 7 1 0 0",
               digit, digit_valid, busy, timeout_err);
    end
  endtask

  task automatic test_stall();
    logic [4:0] ex, ey;
    logic       r;
    int         k;
    int         cyc;
    k = 0;
    cyc = 0;
    start_classify();
    while (k < 784 && cyc < 20000) begin
      ex = 5'(k % 28);
      ey = 5'(k / 28);
      checks++;
      if (pix_valid !== 1'b1 || rd_x !== ex || rd_y !== ey || pix_data !== pix_model(ex, ey) ||
          pix_last !== (k == 783)) begin
        errors++;
        $display("FAIL stall_pix%0d: pv=%b x=%0d y=%0d data=%h last=%b, want pv=1 x=%0d y=%0d data=%h last=%b",
                 k, pix_valid, rd_x, rd_y, pix_data, pix_last, ex, ey, pix_model(ex, ey), k == 783);
      end
      r = ($urandom_range(0, 9) < 3);
      pix_ready = r;
      @(negedge Clk);
      if (r) k++;
      cyc++;
    end
    pix_ready = 1'b0;
    checks++;
    if (k !== 784) begin
      errors++;
      $display("FAIL stall_budget: transfers=%0d, want 784", k);
    end
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_wait: pv=%b busy=%b, want pv=0 busy=1", pix_valid, busy);
    end
    nn_done = 1'b1;
    nn_digit = 4'd3;
    @(negedge Clk);
    nn_done = 1'b0;
    nn_digit = 4'd0;
    checks++;
    if (digit !== 4'd3 || digit_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_result: digit=%0d dv=%b busy=%b, want 3 1 0", digit, digit_valid, busy);
    end
  endtask

  task automatic test_clear_classify();
    draw = 1'b1;
    #1;
    checks++;
    if (canvas_run !== 1'b1 || digit_valid !== 1'b1) begin
      errors++;
      $display("FAIL done_draw: run=%b dv=%b, want 1 1", canvas_run, digit_valid);
    end
    clear = 1'b1;
    classify = 1'b1;
    @(negedge Clk);
    checks++;
    if (canvas_clear !== 1'b1 || canvas_run !== 1'b0 || digit_valid !== 1'b0 ||
        busy !== 1'b0 || pix_valid !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_cycle: clr=%b run=%b dv=%b busy=%b pv=%b terr=%b, want 1 0 0 0 0 0",
               canvas_clear, canvas_run, digit_valid, busy, pix_valid, timeout_err);
    end
    @(negedge Clk);
    clear = 1'b0;
    classify = 1'b0;
    checks++;
    if (canvas_clear !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0 || canvas_run !== 1'b1) begin
      errors++;
      $display("FAIL clear_after: clr=%b busy=%b pv=%b run=%b, want 0 0 0 1",
               canvas_clear, busy, pix_valid, canvas_run);
    end
    @(negedge Clk);
    checks++;
    if (busy !== 1'b0 || canvas_clear !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_scan: busy=%b clr=%b, want 0 0", busy, canvas_clear);
    end
    draw = 1'b0;
  endtask

  task automatic run_scan_fast();
    start_classify();
    pix_ready = 1'b1;
    for (int i = 0; i < 900 && !(pix_valid && pix_last); i++) @(negedge Clk);
    @(negedge Clk);
    pix_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int n;
    run_scan_fast();
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge Clk);
    end
    checks++;
    if (n !== 64) begin
      errors++;
      $display("FAIL timeout_cycles: wait_cycles=%0d, want 64", n);
    end
    checks++;
    if (timeout_err !== 1'b1 || digit_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: terr=%b dv=%b busy=%b, want 1 0 0", timeout_err, digit_valid, busy);
    end
  endtask

  task automatic test_timeout_race();
    run_scan_fast();
    checks++;
    if (timeout_err !== 1'b0 || digit_valid !== 1'b0) begin
      errors++;
      $display("FAIL race_rearm: terr=%b dv=%b, want 0 0", timeout_err, digit_valid);
    end
    repeat (63) @(negedge Clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL race_still_wait: busy=%b, want 1", busy);
    end
    nn_done = 1'b1;
    nn_digit = 4'd9;
    @(negedge Clk);
    nn_done = 1'b0;
    nn_digit = 4'd0;
    checks++;
    if (digit !== 4'd9 || digit_valid !== 1'b1 || timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL race_result: digit=%0d dv=%b terr=%b busy=%b, want 9 1 0 0",
               digit, digit_valid, timeout_err, busy);
    end
  endtask

  task automatic test_ignore();
    logic [4:0] ex, ey;
    draw = 1'b1;
    start_classify();
    pix_ready = 1'b1;
    for (int k = 0; k < 784; k++) begin
      ex = 5'(k % 28);
      ey = 5'(k / 28);
      checks++;
      if (pix_valid !== 1'b1 || rd_x !== ex || rd_y !== ey || canvas_run !== 1'b0 || canvas_clear !== 1'b0) begin
        errors++;
        $display("FAIL ignore_pix%0d: pv=%b x=%0d y=%0d run=%b clr=%b, want pv=1 x=%0d y=%0d run=0 clr=0",
                 k, pix_valid, rd_x, rd_y, canvas_run, canvas_clear, ex, ey);
      end
      clear    = (k == 100);
      classify = (k == 200) || (k == 400);
      nn_done  = (k == 300);
      nn_digit = (k == 300) ? 4'd5 : 4'd0;
      @(negedge Clk);
    end
    clear = 1'b0;
    classify = 1'b0;
    nn_done = 1'b0;
    pix_ready = 1'b0;
    clear = 1'b1;
    @(negedge Clk);
    clear = 1'b0;
    checks++;
    if (busy !== 1'b1 || canvas_clear !== 1'b0 || canvas_run !== 1'b0) begin
      errors++;
      $display("FAIL ignore_wait_clear: busy=%b clr=%b run=%b, want 1 0 0", busy, canvas_clear, canvas_run);
    end
    nn_done = 1'b1;
    nn_digit = 4'd2;
    @(negedge Clk);
    nn_done = 1'b0;
    nn_digit = 4'd0;
    checks++;
    if (digit !== 4'd2 || digit_valid !== 1'b1 || busy !== 1'b0 || canvas_run !== 1'b1) begin
      errors++;
      $display("FAIL ignore_result: digit=%0d dv=%b busy=%b run=%b, want 2 1 0 1",
               digit, digit_valid, busy, canvas_run);
    end
    draw = 1'b0;
  endtask

  initial begin
    @(negedge Clk);
    test_reset();
    test_stream();
    test_stall();
    test_clear_classify();
    test_timeout();
    test_timeout_race();
    test_ignore();
    repeat (2) @(negedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
